// File: rtl/timer_pkg.sv
// Shared definitions for the DMG timer: register offsets, FSM states and
// the TAC clock-select lookup.
package timer_pkg;

  localparam logic [1:0] DIV_OFF  = 2'd0;
  localparam logic [1:0] TIMA_OFF = 2'd1;
  localparam logic [1:0] TMA_OFF  = 2'd2;
  localparam logic [1:0] TAC_OFF  = 2'd3;

  // Cycles TIMA sits at 0x00 after an overflow before the TMA reload.
  localparam int PEND_CYCLES = 4;
  localparam int PEND_W      = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    RELOAD  = 2'd2
  } timer_state_t;

  function automatic logic [3:0] tac_sel_bit(input logic [1:0] clk_sel);
    logic [3:0] bit_idx;
    case (clk_sel)
      2'b00:   bit_idx = 4'd9;
      2'b01:   bit_idx = 4'd3;
      2'b10:   bit_idx = 4'd5;
      default: bit_idx = 4'd7;
    endcase
    return bit_idx;
  endfunction

endpackage

// File: rtl/gb_timer.sv
// DMG timer: DIV/TIMA/TMA/TAC registers, delayed TIMA overflow reload with
// a one-cycle interrupt pulse, and the APU frame-sequencer tick.
//
// state   | meaning
// IDLE    | TIMA counts on falling edges of the selected tick
// PENDING | TIMA overflowed, reads 0x00 while pend_cnt runs down
// RELOAD  | TIMA just took TMA, irq_timer high for this cycle
module gb_timer
  import timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF04,
  parameter int          APU_DIV_BIT = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        read_en,
  input  logic        write_en,
  output logic [7:0]  rdata,
  output logic        irq_timer,
  output logic        apu_tick
);

  logic [15:0]       sys_cnt;
  logic [7:0]        tima, tima_nxt;
  logic [7:0]        tma;
  logic [2:0]        tac;
  logic [PEND_W-1:0] pend_cnt, pend_nxt;
  timer_state_t      state, state_nxt;

  logic        tick_q, apu_q;
  logic        tick_sig, tick_fall;
  logic [15:0] addr_off;
  logic        reg_hit;
  logic        wr_div, wr_tima, wr_tma, wr_tac;

  assign addr_off = addr - BASE_ADDR;
  assign reg_hit  = (addr_off[15:2] == 14'd0);
  assign wr_div   = write_en & reg_hit & (addr_off[1:0] == DIV_OFF);
  assign wr_tima  = write_en & reg_hit & (addr_off[1:0] == TIMA_OFF);
  assign wr_tma   = write_en & reg_hit & (addr_off[1:0] == TMA_OFF);
  assign wr_tac   = write_en & reg_hit & (addr_off[1:0] == TAC_OFF);

  // Edge is taken on the gated signal so DIV resets and TAC changes can
  // produce the spurious increment real hardware shows.
  assign tick_sig  = sys_cnt[tac_sel_bit(tac[1:0])] & tac[2];
  assign tick_fall = tick_q & ~tick_sig;
  assign apu_tick  = apu_q & ~sys_cnt[APU_DIV_BIT];
  assign irq_timer = (state == RELOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sys_cnt <= 16'h0000;
      tick_q  <= 1'b0;
      apu_q   <= 1'b0;
    end else begin
      sys_cnt <= wr_div ? 16'h0000 : sys_cnt + 16'h0001;
      tick_q  <= tick_sig;
      apu_q   <= sys_cnt[APU_DIV_BIT];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tma <= 8'h00;
      tac <= 3'b000;
    end else begin
      if (wr_tma) tma <= wdata;
      if (wr_tac) tac <= wdata[2:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pend_cnt <= '0;
      tima     <= 8'h00;
    end else begin
      state    <= state_nxt;
      pend_cnt <= pend_nxt;
      tima     <= tima_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_cnt;
    tima_nxt  = tima;
    case (state)
      IDLE: begin
        if (wr_tima) begin
          tima_nxt = wdata;
        end else if (tick_fall) begin
          if (tima == 8'hFF) begin
            tima_nxt  = 8'h00;
            pend_nxt  = PEND_W'(PEND_CYCLES - 1);
            state_nxt = PENDING;
          end else begin
            tima_nxt = tima + 8'h01;
          end
        end
      end
      PENDING: begin
        if (wr_tima) begin
          tima_nxt  = wdata;
          state_nxt = IDLE;
        end else if (pend_cnt == '0) begin
          tima_nxt  = tma;
          state_nxt = RELOAD;
        end else begin
          pend_nxt = pend_cnt - 1'b1;
        end
      end
      RELOAD: begin
        // TIMA writes are dropped here; a TMA write lands in both registers.
        if (wr_tma) tima_nxt = wdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdata = 8'hFF;
    if (read_en && reg_hit) begin
      case (addr_off[1:0])
        DIV_OFF:  rdata = sys_cnt[15:8];
        TIMA_OFF: rdata = tima;
        TMA_OFF:  rdata = tma;
        default:  rdata = {5'b11111, tac};
      endcase
    end
  end

endmodule
